// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle for the 5-stage pipeline. The master is the
// pipeline datapath; the slave is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic              regwrite_e;
  logic              memtoreg_e;
  logic              branch_taken_e;
  logic [REG_AW-1:0] rd_m;
  logic              regwrite_m;
  logic              mem_req_m;
  logic              mem_ready_m;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_w;

  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              flush_d;
  logic              flush_e;
  logic              flush_w;
  logic              mem_fault;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, memtoreg_e,
           branch_taken_e, rd_m, regwrite_m, mem_req_m, mem_ready_m,
           rd_w, regwrite_w,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_fault, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, memtoreg_e,
           branch_taken_e, rd_m, regwrite_m, mem_req_m, mem_ready_m,
           rd_w, regwrite_w,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_fault, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for a 5-stage F/D/E/M/W pipeline with a
// memory-wait timeout FSM. Define HAZARD_PERF_EN to build the saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int MAX_WAIT = 16,
  parameter int PERF_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WCNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;

  assign rs1_d = hz.rs1_d;
  assign rs2_d = hz.rs2_d;
  assign rs1_e = hz.rs1_e;
  assign rs2_e = hz.rs2_e;
  assign rd_e  = hz.rd_e;
  assign rd_m  = hz.rd_m;
  assign rd_w  = hz.rd_w;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_nxt;

  logic       lw;
  logic       ms;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_w;
  logic       mem_fault;

  // M result is newer than W result, so it wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] dst_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] dst_w
  );
    if (wr_m && (dst_m == rs) && (dst_m != '0))
      return 2'b10;
    else if (wr_w && (dst_w == rs) && (dst_w != '0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw = hz.memtoreg_e && hz.regwrite_e && (rd_e != '0) &&
              ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign ms = hz.mem_req_m && !hz.mem_ready_m;

  assign fwd_a = fwd_sel(rs1_e, hz.regwrite_m, rd_m, hz.regwrite_w, rd_w);
  assign fwd_b = fwd_sel(rs2_e, hz.regwrite_m, rd_m, hz.regwrite_w, rd_w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A ready on the last allowed wait cycle clears ms, so it never reaches FAULT.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (ms) begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
          if (wait_cnt == WAIT_LAST)
            state_nxt = FAULT;
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      FAULT: begin
        state_nxt    = FAULT;
        wait_cnt_nxt = wait_cnt;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    mem_fault = 1'b0;
    if (!reset) begin
      if (state == FAULT) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        stall_e   = 1'b1;
        stall_m   = 1'b1;
        flush_w   = 1'b1;
        mem_fault = 1'b1;
      end else if (ms) begin
        // Freezing E keeps a taken branch pending until memory completes.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign hz.fwd_a_e   = reset ? 2'b00 : fwd_a;
  assign hz.fwd_b_e   = reset ? 2'b00 : fwd_b;
  assign hz.stall_f   = stall_f;
  assign hz.stall_d   = stall_d;
  assign hz.stall_e   = stall_e;
  assign hz.stall_m   = stall_m;
  assign hz.flush_d   = flush_d;
  assign hz.flush_e   = flush_e;
  assign hz.flush_w   = flush_w;
  assign hz.mem_fault = mem_fault;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_f)
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (flush_d || flush_e)
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end

  assign hz.perf_stall_cnt = perf_stall_cnt;
  assign hz.perf_flush_cnt = perf_flush_cnt;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (REG_AW=4, MAX_WAIT=16, PERF_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW   = 4;
  localparam int MAX_WAIT = 16;
  localparam int PERF_W   = 4;

  logic clk;
  logic reset;

  int tests_run = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) bus();

  pipeline_hazard_ctrl #(
    .REG_AW  (REG_AW),
    .MAX_WAIT(MAX_WAIT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fwd_a, fwd_b, stall f/d/e/m, flush d/e/w, mem_fault}
  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [2:0] fl,
                                     input logic flt);
    return {fa, fb, st, fl, flt};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.fwd_a_e, bus.fwd_b_e, bus.stall_f, bus.stall_d, bus.stall_e,
            bus.stall_m, bus.flush_d, bus.flush_e, bus.flush_w, bus.mem_fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already set at a negedge; outputs are sampled 1 ns later.
  task automatic step(input string tag, input logic [11:0] e);
    logic [11:0] exp_v;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    chk(t, {20'd0, observed()}, {20'd0, exp_v});
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0;
    bus.rd_e = '0; bus.regwrite_e = 1'b0; bus.memtoreg_e = 1'b0;
    bus.branch_taken_e = 1'b0; bus.rd_m = '0; bus.regwrite_m = 1'b0;
    bus.mem_req_m = 1'b0; bus.mem_ready_m = 1'b0; bus.rd_w = '0;
    bus.regwrite_w = 1'b0;
  endtask

  logic [11:0] IDLE, LWS, BR, MS, FLT;

  initial begin
    IDLE = mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    LWS  = mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
    BR   = mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
    MS   = mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    FLT  = mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1);

    idle();
    reset = 1'b1;
    // Outputs stay quiet under reset even with every hazard asserted.
    bus.mem_req_m = 1'b1; bus.branch_taken_e = 1'b1;
    bus.rd_m = 4'd3; bus.regwrite_m = 1'b1; bus.rs1_e = 4'd3;
    @(negedge clk);
    step("reset_quiet", IDLE);
    chk("reset_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    reset = 1'b0; idle();
    step("idle_after_reset", IDLE);

    // Forwarding
    bus.rd_m = 4'd3; bus.regwrite_m = 1'b1; bus.rd_w = 4'd3; bus.regwrite_w = 1'b1;
    bus.rs1_e = 4'd3;
    step("fwd_a_m_prio", mk(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0));
    bus.rd_m = 4'd0;
    step("fwd_a_w_rdm0", mk(2'b01, 2'b00, 4'b0000, 3'b000, 1'b0));
    bus.rd_m = 4'd3; bus.rs2_e = 4'd7; bus.rd_w = 4'd7;
    step("fwd_a_m_b_w", mk(2'b10, 2'b01, 4'b0000, 3'b000, 1'b0));
    bus.rs1_e = 4'd4; bus.rs2_e = 4'd4; bus.rd_m = 4'd4; bus.regwrite_m = 1'b0; bus.rd_w = 4'd4;
    step("fwd_m_nowrite", mk(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0));
    idle(); bus.regwrite_w = 1'b1; bus.regwrite_m = 1'b1;
    step("fwd_x0_never", IDLE);

    // Load-use: one bubble, then clear once the load has moved on
    idle(); bus.memtoreg_e = 1'b1; bus.regwrite_e = 1'b1; bus.rd_e = 4'd5; bus.rs2_d = 4'd5;
    step("lw_bubble", LWS);
    bus.memtoreg_e = 1'b0; bus.regwrite_e = 1'b0; bus.rd_e = 4'd0;
    step("lw_released", IDLE);
    bus.memtoreg_e = 1'b1; bus.regwrite_e = 1'b1; bus.rd_e = 4'd0; bus.rs2_d = 4'd0;
    step("lw_rd0_nostall", IDLE);
    bus.rd_e = 4'd6; bus.rs1_d = 4'd6;
    step("lw_rs1", LWS);
    bus.branch_taken_e = 1'b1;
    step("lw_and_branch", BR);
    idle(); bus.branch_taken_e = 1'b1;
    step("branch_only", BR);

    // Memory wait of 3 cycles with a branch held in E and a load-use pending
    idle(); bus.branch_taken_e = 1'b1; bus.mem_req_m = 1'b1;
    bus.memtoreg_e = 1'b1; bus.regwrite_e = 1'b1; bus.rd_e = 4'd2; bus.rs1_d = 4'd2;
    for (int i = 0; i < 3; i++) step("ms_wait3", MS);
    chk("wait_cnt_after3", 32'(dut.wait_cnt), 32'd3);
    bus.mem_ready_m = 1'b1;
    step("ms_done_branch", BR);
    chk("wait_cnt_cleared", 32'(dut.wait_cnt), 32'd0);

    // MAX_WAIT-1 waits then ready on the boundary cycle: no fault
    idle(); bus.mem_req_m = 1'b1;
    for (int i = 0; i < MAX_WAIT - 1; i++) step("ms_boundary", MS);
    bus.mem_ready_m = 1'b1;
    step("ready_on_last", IDLE);
    idle();
    step("no_fault_boundary", IDLE);

    // MAX_WAIT waits: fault from cycle MAX_WAIT+1, sticky
    bus.mem_req_m = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) step("ms_to_fault", MS);
    step("fault_entered", FLT);
    idle(); bus.branch_taken_e = 1'b1; bus.mem_req_m = 1'b1; bus.mem_ready_m = 1'b1;
    for (int i = 0; i < 3; i++) step("fault_sticky", FLT);

    // Asynchronous reset clears the fault with no clock edge
    #2 reset = 1'b1;
    #1 chk("async_rst_fault", {31'd0, bus.mem_fault}, 32'd0);
    chk("async_rst_stall", {31'd0, bus.stall_f}, 32'd0);
    @(negedge clk);
    reset = 1'b0; idle();
    step("run_after_reset", IDLE);

    // Reset mid-wait clears wait_cnt immediately
    bus.mem_req_m = 1'b1;
    for (int i = 0; i < 4; i++) step("ms_midwait", MS);
    #2 reset = 1'b1;
    #1 chk("async_rst_waitcnt", 32'(dut.wait_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0; idle();

    // Performance counters: 20 stall cycles saturate a 4-bit counter
    bus.mem_req_m = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < MAX_WAIT) step("perf_stall_ms", MS);
      else step("perf_stall_fault", FLT);
    end
`ifdef HAZARD_PERF_EN
    chk("perf_stall_sat", 32'(bus.perf_stall_cnt), 32'd15);
`else
    chk("perf_stall_tied", 32'(bus.perf_stall_cnt), 32'd0);
`endif
    chk("perf_flush_none", 32'(bus.perf_flush_cnt), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; idle(); bus.branch_taken_e = 1'b1;
    for (int i = 0; i < 3; i++) step("perf_branch", BR);
`ifdef HAZARD_PERF_EN
    chk("perf_flush_cnt", 32'(bus.perf_flush_cnt), 32'd3);
`else
    chk("perf_flush_tied", 32'(bus.perf_flush_cnt), 32'd0);
`endif
    chk("perf_stall_rst", 32'(bus.perf_stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
